// File: rtl/xc_malu_pkg.sv
// Shared constants for the MALU sequencer:
// op/pw one-hot indices, FSM encodings and the step counter width.
package xc_malu_pkg;

   localparam int OP_W   = 10;
   localparam int PW_W   = 5;

   localparam int OP_DIV    = 0;
   localparam int OP_DIVU   = 1;
   localparam int OP_REM    = 2;
   localparam int OP_REMU   = 3;
   localparam int OP_MUL    = 4;
   localparam int OP_MULU   = 5;
   localparam int OP_MULSU  = 6;
   localparam int OP_CLMUL  = 7;
   localparam int OP_PMUL   = 8;
   localparam int OP_PCLMUL = 9;

   localparam int PW_32 = 0;
   localparam int PW_16 = 1;
   localparam int PW_8  = 2;
   localparam int PW_4  = 3;
   localparam int PW_2  = 4;

   // Multiply-family ops seed arg_0 from rs2; div/rem seed it from rs1.
   localparam logic [OP_W-1:0] MUL_CLASS_MASK = 10'b11_1111_0000;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int MALU_CNT_W = 6;

endpackage

// File: rtl/xc_malu_seq.sv
// MALU sequencer: accepts an op, steps the datapath registers once per
// cycle until dp_ready (or the MAX_CYCLES budget runs out), then holds
// the 64-bit result until result_ack.
// Ports: clock/reset, valid/in_ready/flush issue side; op_q/pw_q/rs*_q,
// dp_valid, count/acc/arg_* and n_*/dp_ready/dp_result datapath side;
// result/result_valid/timeout/result_ack consumer side.
module xc_malu_seq
   import xc_malu_pkg::*;
#(
   parameter int MAX_CYCLES = 40
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic [OP_W-1:0]       op,
   input  logic [PW_W-1:0]       pw,
   input  logic [31:0]           rs1,
   input  logic [31:0]           rs2,
   input  logic [31:0]           rs3,
   output logic [OP_W-1:0]       op_q,
   output logic [PW_W-1:0]       pw_q,
   output logic [31:0]           rs1_q,
   output logic [31:0]           rs2_q,
   output logic [31:0]           rs3_q,
   output logic                  dp_valid,
   output logic [MALU_CNT_W-1:0] count,
   output logic [63:0]           acc,
   output logic [31:0]           arg_0,
   output logic [31:0]           arg_1,
   input  logic [63:0]           n_acc,
   input  logic [31:0]           n_arg_0,
   input  logic [31:0]           n_arg_1,
   input  logic                  dp_ready,
   input  logic [63:0]           dp_result,
   output logic [63:0]           result,
   output logic                  result_valid,
   input  logic                  result_ack,
   output logic                  timeout
);

   localparam logic [MALU_CNT_W-1:0] CNT_LAST =
      MALU_CNT_W'(MAX_CYCLES - 1);

   logic [1:0] state;
   logic       accept;
   logic       mul_class;

   assign in_ready  = (state == S_IDLE);
   // Malformed (zero or multi-hot) ops are silently refused.
   assign accept    = valid && in_ready && !flush && $onehot(op);
   assign dp_valid  = (state == S_RUN) && !flush;
   assign mul_class = |(op & MUL_CLASS_MASK);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         count        <= '0;
         acc          <= '0;
         arg_0        <= '0;
         arg_1        <= '0;
         op_q         <= '0;
         pw_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rs3_q        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
      end else if (flush) begin
         // acc/args are left as-is; they are reseeded on the next accept.
         state        <= S_IDLE;
         count        <= '0;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q  <= op;
                  pw_q  <= pw;
                  rs1_q <= rs1;
                  rs2_q <= rs2;
                  rs3_q <= rs3;
                  count <= '0;
                  acc   <= '0;
                  arg_0 <= mul_class ? rs2 : rs1;
                  arg_1 <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (dp_ready) begin
                  // dp_ready is derived from the current registers,
                  // so they must not advance on the finishing cycle.
                  result       <= dp_result;
                  result_valid <= 1'b1;
                  state        <= S_DONE;
               end else if (count == CNT_LAST) begin
                  result       <= '0;
                  timeout      <= 1'b1;
                  result_valid <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  acc   <= n_acc;
                  arg_0 <= n_arg_0;
                  arg_1 <= n_arg_1;
                  count <= count + 1'b1;
               end
            end
            S_DONE: begin
               if (result_ack) begin
                  result_valid <= 1'b0;
                  timeout      <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xc_malu_seq.sv
// Randomized bench for xc_malu_seq with a stub datapath that finishes
// after a chosen number of steps and a plain-arithmetic result model.
module tb_xc_malu_seq;
   import xc_malu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic [9:0]  op = '0;
   logic [4:0]  pw = '0;
   logic [31:0] rs1 = '0, rs2 = '0, rs3 = '0;
   logic [9:0]  op_q;
   logic [4:0]  pw_q;
   logic [31:0] rs1_q, rs2_q, rs3_q;
   logic        dp_valid;
   logic [5:0]  count;
   logic [63:0] acc;
   logic [31:0] arg_0, arg_1;
   logic [63:0] n_acc;
   logic [31:0] n_arg_0, n_arg_1;
   logic        dp_ready;
   logic [63:0] dp_result;
   logic [63:0] result;
   logic        result_valid;
   logic        result_ack = 1'b0;
   logic        timeout;

   int          k_cur = 100;
   logic [63:0] exp_res = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   // Stub datapath: finishes when count reaches k_cur.
   assign dp_ready  = (int'(count) == k_cur);
   assign dp_result = exp_res;
   assign n_acc     = acc + {32'b0, rs1_q};
   assign n_arg_0   = arg_0 + 32'd1;
   assign n_arg_1   = arg_1 + 32'd2;

   xc_malu_seq #(.MAX_CYCLES(40)) dut (
      .clock(clock), .reset(reset), .valid(valid), .in_ready(in_ready),
      .flush(flush), .op(op), .pw(pw), .rs1(rs1), .rs2(rs2), .rs3(rs3),
      .op_q(op_q), .pw_q(pw_q), .rs1_q(rs1_q), .rs2_q(rs2_q),
      .rs3_q(rs3_q), .dp_valid(dp_valid), .count(count), .acc(acc),
      .arg_0(arg_0), .arg_1(arg_1), .n_acc(n_acc), .n_arg_0(n_arg_0),
      .n_arg_1(n_arg_1), .dp_ready(dp_ready), .dp_result(dp_result),
      .result(result), .result_valid(result_valid),
      .result_ack(result_ack), .timeout(timeout)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [63:0] clmul(logic [31:0] a, logic [31:0] b);
      logic [63:0] r = '0;
      for (int i = 0; i < 32; i++)
         if (b[i]) r = r ^ ({32'b0, a} << i);
      return r;
   endfunction

   function automatic logic [63:0] model(logic [9:0] o, logic [31:0] a,
                                         logic [31:0] b);
      logic [31:0] q;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      q = '0;
      if (o[OP_DIV])
         q = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      else if (o[OP_REM])
         q = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      else if (o[OP_DIVU])
         q = (b == 0) ? 32'hFFFF_FFFF : a / b;
      else if (o[OP_REMU])
         q = (b == 0) ? a : a % b;
      else if (o[OP_MUL])
         return 64'(longint'($signed(a)) * longint'($signed(b)));
      else if (o[OP_MULSU])
         return 64'(longint'($signed(a)) * longint'({32'b0, b}));
      else if (o[OP_MULU] || o[OP_PMUL])
         return {32'b0, a} * {32'b0, b};
      else
         return clmul(a, b);
      return {32'b0, q};
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, in_ready, 1);
      check({tag, "_dpv"}, dp_valid, 0);
      check({tag, "_cnt"}, count, 0);
      check({tag, "_acc"}, acc, 0);
      check({tag, "_arg0"}, arg_0, 0);
      check({tag, "_arg1"}, arg_1, 0);
      check({tag, "_opq"}, op_q, 0);
      check({tag, "_pwq"}, pw_q, 0);
      check({tag, "_rsq"}, {rs1_q, rs2_q}, 0);
      check({tag, "_rs3q"}, rs3_q, 0);
      check({tag, "_res"}, result, 0);
      check({tag, "_rv"}, result_valid, 0);
      check({tag, "_to"}, timeout, 0);
   endtask

   task automatic run_op(input logic [9:0] o, input logic [4:0] w,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input int k,
                         input int hold, output logic [63:0] res);
      int          steps, n;
      logic        is_mul;
      logic [31:0] a0;
      logic [63:0] r0;
      is_mul  = (o[9:4] != 0);
      a0      = is_mul ? b : a;
      exp_res = model(o, a, b);
      k_cur   = k;
      steps   = (k <= 39) ? k : 39;
      check("idle_ready", in_ready, 1);
      op = o; pw = w; rs1 = a; rs2 = b; rs3 = c; valid = 1;
      step();
      valid = 0;
      check("acc_ready", in_ready, 0);
      check("acc_dpv", dp_valid, 1);
      check("acc_cnt", count, 0);
      check("acc_acc", acc, 0);
      check("acc_arg0", arg_0, a0);
      check("acc_arg1", arg_1, 0);
      check("acc_opq", op_q, o);
      check("acc_pwq", pw_q, w);
      check("acc_rs3q", rs3_q, c);
      n = 0;
      while (!result_valid && n < 60) begin
         step();
         n++;
      end
      check("latency", n, steps + 1);
      check("timeout", timeout, k > 39);
      check("result", result, (k > 39) ? 64'd0 : exp_res);
      check("end_acc", acc, 64'(steps) * {32'b0, a});
      check("end_arg0", arg_0, a0 + 32'(steps));
      check("end_arg1", arg_1, 32'(2 * steps));
      res = result;
      r0  = result;
      // A request while the result is pending must be ignored.
      valid = 1; op = 10'b1 << OP_MULU;
      for (int i = 0; i < hold; i++) begin
         step();
         check("hold_rv", result_valid, 1);
         check("hold_res", result, r0);
         check("hold_ready", in_ready, 0);
         check("hold_to", timeout, k > 39);
      end
      valid = 0;
      result_ack = 1;
      step();
      result_ack = 0;
      check("ack_rv", result_valid, 0);
      check("ack_to", timeout, 0);
      check("ack_ready", in_ready, 1);
      check("ack_opq", op_q, o);
   endtask

   initial begin
      logic [63:0] r;
      logic        seen;
      #2;
      check_reset_vals("rst");
      #10 reset = 0;
      step();

      run_op(10'b1 << OP_MUL, 5'b1 << PW_32, 3, 5, 0, 6, 0, r);
      check("mul_3x5", r[31:0], 15);
      run_op(10'b1 << OP_DIV, 5'b1 << PW_32, 7, 32'hFFFF_FFFE, 9, 12, 1, r);
      check("div_7_m2", r[31:0], 32'hFFFF_FFFD);
      run_op(10'b1 << OP_REM, 5'b1 << PW_16, 7, 32'hFFFF_FFFE, 0, 3, 0, r);
      check("rem_7_m2", r[31:0], 1);
      run_op(10'b1 << OP_MULU, 5'b1 << PW_8, 11, 13, 1, 100, 5, r);
      run_op(10'b1 << OP_DIVU, 5'b1 << PW_32, 100, 7, 2, 39, 0, r);
      run_op(10'b1 << OP_PMUL, 5'b1 << PW_2, 4, 6, 3, 40, 0, r);
      run_op(10'b1 << OP_CLMUL, 5'b1 << PW_4, 5, 3, 4, 0, 2, r);

      // Flush mid-run.
      k_cur = 100;
      op = 10'b1 << OP_DIVU; rs1 = 50; rs2 = 3; valid = 1;
      step();
      valid = 0;
      for (int i = 0; i < 10; i++) step();
      check("fl_cnt10", count, 10);
      flush = 1;
      #1;
      check("fl_dpv", dp_valid, 0);
      step();
      flush = 0;
      check("fl_ready", in_ready, 1);
      check("fl_cnt", count, 0);
      check("fl_rv", result_valid, 0);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (result_valid || dp_valid) seen = 1;
      end
      check("fl_quiet", seen, 0);

      // Asynchronous reset mid-run.
      k_cur = 30;
      op = 10'b1 << OP_MUL; rs1 = 9; rs2 = 8; rs3 = 7; valid = 1;
      step();
      valid = 0;
      for (int i = 0; i < 5; i++) step();
      #2 reset = 1;
      #1;
      check_reset_vals("arst");
      #2 reset = 0;
      step();
      check_reset_vals("arst_post");

      // valid with flush: refused.
      op = 10'b1 << OP_MUL; valid = 1; flush = 1;
      step();
      valid = 0; flush = 0;
      check("vf_ready", in_ready, 1);
      check("vf_dpv", dp_valid, 0);
      check("vf_opq", op_q, 0);

      // Malformed ops: refused.
      op = 10'b0; valid = 1;
      step();
      check("op0_ready", in_ready, 1);
      check("op0_opq", op_q, 0);
      op = 10'b0000_0000_11;
      step();
      valid = 0;
      check("op2_ready", in_ready, 1);
      check("op2_dpv", dp_valid, 0);
      check("op2_opq", op_q, 0);

      for (int t = 0; t < 25; t++) begin
         logic [9:0]  o;
         logic [4:0]  w;
         o = 10'b1 << $urandom_range(0, 9);
         w = 5'b1 << $urandom_range(0, 4);
         run_op(o, w, $urandom, $urandom, $urandom,
                $urandom_range(0, 45), $urandom_range(0, 3), r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
